// File: rtl/fetch_unit_if.sv
// fetch_unit_if: single-outstanding instruction memory port.
// Master issues requests, slave returns one word per request.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, imem requester and IF/ID register.
// Handles load-use hold, predicted-taken kills and redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         pred_taken,
  input  logic [31:0]  pred_target,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  fetch_unit_if.master imem,
  output logic [31:0]  if_id_pc,
  output logic [31:0]  if_id_inst,
  output logic         if_id_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  localparam logic [31:0] ALIGN = ~32'd3;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_buf;
  logic [31:0] w_buf_nxt;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_if_valid;

  logic        w_kill;
  logic [31:0] w_tgt_raw;
  logic [31:0] w_tgt;
  logic [31:0] w_pc_inc;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_dlv;
  logic [31:0] w_dlv_inst;

  // Kill decode: a redirect wins over a prediction.
  always_comb begin
    w_kill    = redirect |
                (pred_taken & r_if_valid & ~stall);
    w_tgt_raw = redirect ? redirect_pc : pred_target;
    w_tgt     = w_tgt_raw & ALIGN;
    w_pc_inc  = r_pc + 32'd4;
  end

  // Next state, next pc, request and delivery decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_req       = 1'b0;
    w_addr      = r_pc;
    w_dlv       = 1'b0;
    w_dlv_inst  = imem.imem_rdata;
    unique case (r_state)
      S_IDLE: begin
        w_req       = 1'b1;
        w_state_nxt = S_WAIT;
        if (w_kill) begin
          w_addr   = w_tgt;
          w_pc_nxt = w_tgt;
        end
      end
      S_WAIT: begin
        if (imem.imem_valid) begin
          if (w_kill) begin
            w_req    = 1'b1;
            w_addr   = w_tgt;
            w_pc_nxt = w_tgt;
          end else if (stall) begin
            w_buf_nxt   = imem.imem_rdata;
            w_state_nxt = S_HOLD;
          end else begin
            w_dlv    = 1'b1;
            w_req    = 1'b1;
            w_addr   = w_pc_inc;
            w_pc_nxt = w_pc_inc;
          end
        end else if (w_kill) begin
          w_pc_nxt    = w_tgt;
          w_state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (w_kill) begin
          w_req       = 1'b1;
          w_addr      = w_tgt;
          w_pc_nxt    = w_tgt;
          w_state_nxt = S_WAIT;
        end else if (!stall) begin
          w_dlv       = 1'b1;
          w_dlv_inst  = r_buf;
          w_req       = 1'b1;
          w_addr      = w_pc_inc;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_WAIT;
        end
      end
      S_DROP: begin
        if (w_kill) begin
          w_pc_nxt = w_tgt;
        end
        if (imem.imem_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The request must stay low while reset is held.
  always_comb begin
    imem.imem_req  = w_req & rst;
    imem.imem_addr = w_addr;
  end

  // FSM, pc and pending-word registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC & ALIGN;
      r_buf   <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // IF/ID: redirect flush, then stall hold, then load or bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_pc    <= 32'd0;
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
    end else if (redirect) begin
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
    end else if (stall) begin
      r_if_pc    <= r_if_pc;
    end else if (w_dlv) begin
      r_if_pc    <= r_pc;
      r_if_inst  <= w_dlv_inst;
      r_if_valid <= 1'b1;
    end else begin
      r_if_inst  <= NOP_INST;
      r_if_valid <= 1'b0;
    end
  end

  assign if_id_pc    = r_if_pc;
  assign if_id_inst  = r_if_inst;
  assign if_id_valid = r_if_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a
// small latency-programmable memory returning addr|0x100.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;

  int total = 0;
  int bad   = 0;
  int lat   = 1;

  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;

  fetch_unit_if u_if ();

  fetch_unit u_dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (u_if),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: response lat cycles after the request edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_if.imem_valid <= 1'b0;
      u_if.imem_rdata <= 32'd0;
      m_busy          <= 1'b0;
      m_cnt           <= 0;
      m_addr          <= 32'd0;
    end else begin
      u_if.imem_valid <= 1'b0;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          u_if.imem_valid <= 1'b1;
          u_if.imem_rdata <= m_addr | 32'h100;
          m_busy          <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (u_if.imem_req) begin
        if (lat <= 1) begin
          u_if.imem_valid <= 1'b1;
          u_if.imem_rdata <= u_if.imem_addr | 32'h100;
        end else begin
          m_busy <= 1'b1;
          m_addr <= u_if.imem_addr;
          m_cnt  <= lat - 1;
        end
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'd0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    #1;
    rst = 1'b0;
    #1;
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_inst", if_id_inst, NOP);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_req", {31'd0, u_if.imem_req}, 32'd0);
    step;
    step;
    rst = 1'b1;

    // streaming at one instruction per cycle
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("str_req", {31'd0, u_if.imem_req}, 32'd1);
      chk("str_addr", u_if.imem_addr, 32'(4 * i));
      if (i >= 2) begin
        chk("str_inst", if_id_inst, 32'h100 + 32'(4 * (i - 2)));
        chk("str_pc", if_id_pc, 32'(4 * (i - 2)));
        chk("str_valid", {31'd0, if_id_valid}, 32'd1);
      end
      step;
    end

    // two-cycle stall while a response lands
    stall = 1'b1;
    #1;
    chk("stl0_req", {31'd0, u_if.imem_req}, 32'd0);
    chk("stl0_inst", if_id_inst, 32'h10C);
    step;
    #1;
    chk("stl1_req", {31'd0, u_if.imem_req}, 32'd0);
    chk("stl1_pc", if_id_pc, 32'd12);
    chk("stl1_inst", if_id_inst, 32'h10C);
    step;
    stall = 1'b0;
    #1;
    chk("stl2_inst", if_id_inst, 32'h10C);
    chk("stl2_req", {31'd0, u_if.imem_req}, 32'd1);
    chk("stl2_addr", u_if.imem_addr, 32'd20);
    step;
    lat = 2;
    #1;
    chk("held_pc", if_id_pc, 32'd16);
    chk("held_inst", if_id_inst, 32'h110);
    chk("held_valid", {31'd0, if_id_valid}, 32'd1);
    chk("held_addr", u_if.imem_addr, 32'd24);
    step;

    // prediction kill with a request in flight
    pred_taken  = 1'b1;
    pred_target = 32'h40;
    #1;
    chk("pk0_req", {31'd0, u_if.imem_req}, 32'd0);
    chk("pk0_valid", {31'd0, if_id_valid}, 32'd1);
    step;
    pred_taken = 1'b0;
    lat = 1;
    #1;
    chk("pk1_valid", {31'd0, if_id_valid}, 32'd0);
    chk("pk1_inst", if_id_inst, NOP);
    chk("pk1_pc", if_id_pc, 32'd20);
    chk("pk1_req", {31'd0, u_if.imem_req}, 32'd0);
    step;
    #1;
    chk("pk2_req", {31'd0, u_if.imem_req}, 32'd1);
    chk("pk2_addr", u_if.imem_addr, 32'h40);
    step;
    #1;
    chk("pk3_addr", u_if.imem_addr, 32'h44);
    step;

    // redirect together with stall and a response
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h202;
    #1;
    chk("pk4_pc", if_id_pc, 32'h40);
    chk("pk4_inst", if_id_inst, 32'h140);
    chk("rd0_req", {31'd0, u_if.imem_req}, 32'd1);
    chk("rd0_addr", u_if.imem_addr, 32'h200);
    step;
    stall    = 1'b0;
    redirect = 1'b0;
    #1;
    chk("rd1_inst", if_id_inst, NOP);
    chk("rd1_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rd1_pc", if_id_pc, 32'h40);
    chk("rd1_addr", u_if.imem_addr, 32'h204);
    step;

    // pc wraps past the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("rd2_pc", if_id_pc, 32'h200);
    chk("rd2_inst", if_id_inst, 32'h300);
    chk("wr0_addr", u_if.imem_addr, 32'hFFFF_FFFC);
    step;
    redirect = 1'b0;
    #1;
    chk("wr1_valid", {31'd0, if_id_valid}, 32'd0);
    chk("wr1_addr", u_if.imem_addr, 32'd0);
    step;
    lat = 2;
    #1;
    chk("wr2_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wr2_inst", if_id_inst, 32'hFFFF_FFFC);
    chk("wr2_valid", {31'd0, if_id_valid}, 32'd1);
    chk("wr2_addr", u_if.imem_addr, 32'd4);
    step;

    // asynchronous reset in the middle of a wait
    #1;
    chk("mw_req", {31'd0, u_if.imem_req}, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_pc", if_id_pc, 32'd0);
    chk("ar_inst", if_id_inst, NOP);
    chk("ar_valid", {31'd0, if_id_valid}, 32'd0);
    chk("ar_req", {31'd0, u_if.imem_req}, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("rr_req", {31'd0, u_if.imem_req}, 32'd1);
    chk("rr_addr", u_if.imem_addr, 32'd0);
    step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
